// File: rtl/uart_rx_8n1.sv
// 8N1 asynchronous serial receiver with 16x oversampling, mid-bit sampling and
// frame-error detection. The byte is presented with a single-cycle valid strobe.
module uart_rx_8n1 #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCNT_W   = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  logic              rx_meta;
  logic              rxs;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;

  state_t            state, state_n;
  logic [SCNT_W-1:0] scnt, scnt_n;
  logic [2:0]        bcnt, bcnt_n;
  logic [7:0]        shreg, shreg_n;
  logic [7:0]        data_n;
  logic              valid_n;
  logic              ferr_n;
  logic              busy_n;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running oversample tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      scnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_n;
      scnt         <= scnt_n;
      bcnt         <= bcnt_n;
      shreg        <= shreg_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
      rx_busy      <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;

    if (tick_c) begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state_n = ST_START;
            scnt_n  = '0;
          end
        end
        ST_START: begin
          // Re-check at mid start bit to reject glitches.
          if (scnt == SCNT_MID) begin
            scnt_n = '0;
            if (!rxs) begin
              state_n = ST_DATA;
              bcnt_n  = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (scnt == SCNT_LAST) begin
            scnt_n  = '0;
            shreg_n = {rxs, shreg[7:1]};
            if (bcnt == 3'd7) begin
              state_n = ST_STOP;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        ST_STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (scnt == SCNT_LAST) begin
            scnt_n = '0;
            if (rxs) begin
              data_n  = shreg;
              valid_n = 1'b1;
              state_n = ST_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BRK;
            end
          end else begin
            scnt_n = scnt + 1'b1;
          end
        end
        ST_BRK: begin
          if (rxs) begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: stimulus pushes expected frames, a monitor
// pops and compares on every rx_valid / rx_frame_err pulse.
module tb_uart_rx_8n1;

  localparam int unsigned OVS  = 16;
  localparam int unsigned BAUD = 9600;
  localparam int unsigned DIV  = 4;
  localparam int unsigned CLKF = BAUD * OVS * DIV;
  localparam int          BIT  = OVS * DIV;
  localparam int          BIT_SLOW = 66;
  localparam int          BIT_FAST = 62;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         n_checks;
  int         n_pass;

  uart_rx_8n1 #(
    .CLK_HZ    (CLKF),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; the expected outcome is queued before the line moves.
  task automatic send_byte(input logic [7:0] b, input int bit_clks, input bit stop_val);
    exp_t e;
    e.err  = !stop_val;
    e.data = b;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bit_clks);
    end
    rx = stop_val;
    wait_clks(bit_clks);
  endtask

  // Monitor: compares every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || rx_frame_err)) begin
      chk("pulse_exclusive", 8'(rx_valid & rx_frame_err), 8'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=%h with nothing expected",
                 rx_valid, rx_frame_err, rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_err", 8'(rx_frame_err), 8'(e.err));
        if (e.err) begin
          chk("data_held_on_err", rx_data, last_good);
        end else begin
          chk("rx_data", rx_data, e.data);
          last_good = e.data;
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] c3;
    int         p;
    n_checks  = 0;
    n_pass    = 0;
    last_good = 8'h00;
    rst_n     = 1'b0;
    rx        = 1'b1;
    wait_clks(5);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", 8'(rx_valid), 8'd0);
    chk("reset_ferr", 8'(rx_frame_err), 8'd0);
    chk("reset_busy", 8'(rx_busy), 8'd0);
    rst_n = 1'b1;
    wait_clks(20);

    send_byte(8'h46, BIT, 1'b1);
    wait_clks(BIT);

    send_byte(8'h55, BIT, 1'b1);
    send_byte(8'h00, BIT, 1'b1);
    send_byte(8'hFF, BIT, 1'b1);
    wait_clks(BIT);
    chk("idle_busy_after_b2b", 8'(rx_busy), 8'd0);

    // Short low glitch: three ticks only.
    rx = 1'b0;
    wait_clks(10);
    chk("glitch_busy_high", 8'(rx_busy), 8'd1);
    wait_clks(3 * DIV - 10);
    rx = 1'b1;
    wait_clks(2 * BIT);
    chk("glitch_busy_drops", 8'(rx_busy), 8'd0);
    chk("glitch_data_hold", rx_data, 8'hFF);

    // Bad stop bit followed by a held-low line.
    send_byte(8'hA5, BIT, 1'b0);
    wait_clks(2 * BIT);
    chk("break_busy_held", 8'(rx_busy), 8'd1);
    chk("break_data_hold", rx_data, 8'hFF);
    rx = 1'b1;
    wait_clks(BIT);
    chk("break_released", 8'(rx_busy), 8'd0);
    send_byte(8'h3C, BIT, 1'b1);
    wait_clks(BIT);

    // Reset during data bit 4 of 8'hC3.
    c3 = 8'hC3;
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      wait_clks(BIT);
    end
    rx = c3[4];
    wait_clks(BIT / 2);
    rst_n = 1'b0;
    wait_clks(3);
    last_good = 8'h00;
    chk("midreset_data", rx_data, 8'h00);
    chk("midreset_valid", 8'(rx_valid), 8'd0);
    chk("midreset_ferr", 8'(rx_frame_err), 8'd0);
    chk("midreset_busy", 8'(rx_busy), 8'd0);
    rx = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(2 * BIT);
    chk("post_reset_busy", 8'(rx_busy), 8'd0);
    chk("post_reset_data", rx_data, 8'h00);
    send_byte(8'h12, BIT, 1'b1);
    wait_clks(BIT);

    // Baud mismatch of about +-3 %.
    send_byte(8'h96, BIT_SLOW, 1'b1);
    wait_clks(BIT);
    send_byte(8'h96, BIT_FAST, 1'b1);
    wait_clks(BIT);

    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      p = int'($urandom_range(BIT_FAST, BIT_SLOW));
      send_byte(b, p, 1'b1);
      wait_clks(int'($urandom_range(0, 40)));
    end
    wait_clks(BIT);

    for (int t = 0; t < 4 * BIT && exp_q.size() != 0; t++) wait_clks(1);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    chk("final_busy", 8'(rx_busy), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
